// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver. A BCD snapshot is taken once per frame;
// each slot starts with an all-off window, and leading zeros can be suppressed.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 27000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0][3:0]  digits,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]    cnt;
  logic [1:0]       idx;
  logic [3:0][3:0]  snap;

  logic [3:0]       sup;
  logic             en;
  logic [3:0]       cur;

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b0111111;
    endcase
  endfunction

  // A digit is dark only when it and every more-significant digit are zero.
  always_comb begin
    sup = 4'b0000;
    if (LZ_BLANK != 0) begin
      sup[3] = (snap[3] == 4'd0);
      sup[2] = sup[3] && (snap[2] == 4'd0);
      sup[1] = sup[2] && (snap[1] == 4'd0);
    end
  end

  assign cur = snap[idx];
  assign en  = (int'(cnt) >= BLANK_CYCLES) && !sup[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= 2'd0;
      snap <= '0;
      an   <= 4'b1111;
      seg  <= 7'b1111111;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
        if (idx == 2'd3)
          snap <= digits;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (en) begin
        an  <= ~(4'b0001 << idx);
        seg <= pattern(cur);
      end else begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with an 8-cycle slot and a 2-cycle blank window.
module tb_seg7_scan_driver;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;

  logic            clk;
  logic            rst;
  logic [3:0][3:0] digits;
  logic [3:0]      an;
  logic [6:0]      seg;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK), .LZ_BLANK(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .digits (digits),
    .an     (an),
    .seg    (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010,
                         P7 = 7'b1111000, P9 = 7'b0010000, PDASH = 7'b0111111,
                         POFF = 7'b1111111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // One 32-cycle frame, sampled at the falling edge after each rising edge.
  // Optionally changes digits right after sample chg_pos.
  task automatic check_frame(input string tag, input logic [3:0] lit,
                             input logic [3:0][6:0] segs,
                             input int chg_pos, input logic [15:0] chg_val);
    for (int p = 0; p < 4*RDIV; p++) begin
      int s, c;
      logic [3:0] ea;
      logic [6:0] es;
      s = p / RDIV;
      c = p % RDIV;
      @(posedge clk);
      @(negedge clk);
      if (c < BLANK || !lit[s]) begin
        ea = 4'b1111;
        es = POFF;
      end else begin
        ea = ~(4'b0001 << s);
        es = segs[s];
      end
      chk($sformatf("%s an p%0d", tag, p), 32'(an), 32'(ea));
      chk($sformatf("%s seg p%0d", tag, p), 32'(seg), 32'(es));
      if (p == chg_pos) digits = chg_val;
    end
  endtask

  initial begin
    rst    = 1'b1;
    digits = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset an", 32'(an), 32'hF);
      chk("reset seg", 32'(seg), 32'(POFF));
    end
    rst = 1'b0;

    check_frame("zero_f0", 4'b0001, {POFF, POFF, POFF, P0}, -1, 16'h0);
    digits = {4'd1, 4'd2, 4'd3, 4'd4};
    check_frame("zero_f1", 4'b0001, {POFF, POFF, POFF, P0}, -1, 16'h0);
    check_frame("full",    4'b1111, {P1, P2, P3, P4}, -1, 16'h0);
    digits = {4'd0, 4'd0, 4'd0, 4'd5};
    check_frame("full_hold", 4'b1111, {P1, P2, P3, P4}, -1, 16'h0);
    check_frame("lz_5",    4'b0001, {POFF, POFF, POFF, P5}, -1, 16'h0);
    digits = {4'd0, 4'd7, 4'd0, 4'd0};
    check_frame("lz_5_hold", 4'b0001, {POFF, POFF, POFF, P5}, -1, 16'h0);
    check_frame("lz_700",  4'b0111, {POFF, P7, P0, P0}, -1, 16'h0);
    digits = {4'd0, 4'd0, 4'd0, 4'd1};
    check_frame("lz_700_hold", 4'b0111, {POFF, P7, P0, P0}, -1, 16'h0);
    check_frame("tear_1",  4'b0001, {POFF, POFF, POFF, P1}, 10, {4'd0, 4'd0, 4'd0, 4'd9});
    check_frame("tear_9",  4'b0001, {POFF, POFF, POFF, P9}, 0, {4'd0, 4'd0, 4'd0, 4'hB});
    check_frame("invalid", 4'b0001, {POFF, POFF, POFF, PDASH}, -1, 16'h0);

    // Stop right after the state reaches slot 2, cnt 5, then pulse reset.
    for (int p = 0; p < 2*RDIV + 5; p++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst an", 32'(an), 32'hF);
    chk("midrst seg", 32'(seg), 32'(POFF));
    rst = 1'b0;
    check_frame("midrst_f0", 4'b0001, {POFF, POFF, POFF, P0}, -1, 16'h0);
    check_frame("midrst_f1", 4'b0001, {POFF, POFF, POFF, PDASH}, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed 4-digit seven-segment display driver, directly downstream of the registered digit selector that chooses between the digits being entered and the computed result. Takes the selected 4-digit BCD word (`digits`, digit 0 = least significant), snapshots it once per scan frame, and drives one digit at a time. Each digit slot has an anti-ghosting blank window and leading-zero suppression. Outputs are registered and drive the board display pins directly.

## Interface
- `REFRESH_DIV`, 27000: clock cycles per digit slot. Constraint: `REFRESH_DIV >= BLANK_CYCLES + 2`.
- `BLANK_CYCLES`, 16: cycles at the start of each slot during which all anodes are off. 0 is legal.
- `LZ_BLANK`, 1: 1 enables leading-zero suppression; 0 displays all four digits always.

- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `digits`  in  [3:0][3:0]: BCD digits from the selector; `digits[0]` is least significant.
- `an`  out  4: digit enables, active-low, one-hot-low or all-high.
- `seg`  out  7: segments active-low, `seg[0]`=a … `seg[6]`=g.

## Operation
- State:
  - prescaler `cnt`, counts 0..REFRESH_DIV-1;
  - slot index `idx`, 0..3;
  - snapshot `snap` [3:0][3:0].
- `cnt` increments every cycle. At REFRESH_DIV-1 it wraps to 0 and `idx` increments mod 4 (3→0).
- `snap` loads `digits` on the cycle where `cnt`=REFRESH_DIV-1 and `idx`=3, i.e. as the frame wraps to slot 0. At no other time does the displayed value change, so there is no mid-frame tearing.
- Digit enable for slot `idx`: `cnt >= BLANK_CYCLES` AND the digit is not suppressed.
- Leading-zero suppression (LZ_BLANK=1):
  - digit k (k = 1..3) is suppressed iff `snap[j]`==0 for all j ≥ k;
  - digit 0 is never suppressed;
  - suppression depends only on `snap`, never on `digits`.
- When enabled: `an` = ~(1<<idx), `seg` = pattern(`snap[idx]`).
- When not enabled: `an`=4'b1111, `seg`=7'b1111111.
- Patterns as seg[6:0]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 (invalid BCD) = 0111111, a dash showing segment g only.
- Invalid codes count as non-zero for suppression.

## Timing
- Reset, synchronous: `cnt`=0, `idx`=0, `snap`=0, `an`=4'b1111, `seg`=7'b1111111. These values are visible after the first rising edge with `rst`=1.
- `an`/`seg` are registered. The values after edge t are computed from `cnt`/`idx`/`snap` before edge t, which gives one cycle of latency from the state.
- Post-reset frame:
  - `snap`=0, so only digit 0 shows "0";
  - new `digits` appear from the second frame onward. Worst-case latency from a `digits` change to display is 2 frames (8·REFRESH_DIV cycles).
- Within each slot:
  - `an` is all-high for BLANK_CYCLES cycles;
  - then the slot's digit is on for REFRESH_DIV−BLANK_CYCLES cycles.
- `rst` asserted mid-frame: the next edge forces the reset values regardless of `cnt`/`idx`; the scan restarts at slot 0.
- `rst` has priority over the snapshot load and the counter wrap when they coincide.
- `an` never has more than one bit low on any cycle.

## Test plan
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1.
- Reset: hold `rst` 3 cycles, then release with `digits`=0.
  - During reset: `an`=1111, `seg`=1111111.
  - After the 3rd post-release edge: `an`=1110, `seg`=1000000 for 6 cycles, then 1111 for the other 3 slots.
  - Period repeats every 32 cycles.
- Full number: `digits`={1,2,3,4}, i.e. digits[3]=1.
  - Second frame: slot0 `an`=1110, `seg`=0011001; slot1 1101/0110000; slot2 1011/0100100; slot3 0111/1111001.
  - Each slot has exactly 2 blank cycles before it.
- Leading zeros:
  - {0,0,0,5}: only slot0 lights, `seg`=0010010.
  - {0,7,0,0}: slot2 shows 1111000, slots 1 and 0 show 1000000, slot3 stays dark.
- Tearing: change `digits` from {0,0,0,1} to {0,0,0,9} while `idx`=1. `seg` for slot 0 stays 1111001 until the next frame's slot 0, then becomes 0010000.
- Invalid code: `digits`={0,0,0,4'hB} → slot0 `seg`=0111111.
- Mid-scan reset: assert `rst` for 1 cycle while `idx`=2, `cnt`=5. The next edge gives `an`=1111, `snap`=0, and the scan restarts at slot 0 with the timing of the reset scenario.
